// File: rtl/display_capture_pkg.sv
// Shared definitions for the display capture block: default sizing and dump FSM states.
package display_capture_pkg;
  localparam int unsigned DEF_SEGMENTS   = 1;
  localparam int unsigned DEF_ROWS       = 8;
  localparam int unsigned DEF_COLUMNS    = 32;
  localparam int unsigned DEF_CYCLEWIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } dump_state_t;
endpackage

// File: rtl/display_capture_if.sv
// Panel-side inputs and pixel-write outputs of display_capture, bundled as one interface.
interface display_capture_if import display_capture_pkg::*; #(
  parameter int unsigned segments   = DEF_SEGMENTS,
  parameter int unsigned rows       = DEF_ROWS,
  parameter int unsigned columns    = DEF_COLUMNS,
  parameter int unsigned cyclewidth = DEF_CYCLEWIDTH
);
  localparam int unsigned NP = 3 * segments;
  localparam int unsigned IW = cyclewidth + 1;
  localparam int unsigned RW = (rows > 1) ? $clog2(rows) : 1;
  localparam int unsigned CW = (columns > 1) ? $clog2(columns) : 1;

  logic [NP-1:0]    rgb;
  logic             oclk;
  logic             lat;
  logic             oe;
  logic [RW-1:0]    row;
  logic             wr_valid;
  logic [RW-1:0]    wr_row;
  logic [CW-1:0]    wr_column;
  logic [IW*NP-1:0] wr_pixel;
  logic             frame_done;
  logic             shift_error;
  logic             overrun;

  modport master (
    output rgb, oclk, lat, oe, row,
    input  wr_valid, wr_row, wr_column, wr_pixel, frame_done, shift_error, overrun
  );

  modport slave (
    input  rgb, oclk, lat, oe, row,
    output wr_valid, wr_row, wr_column, wr_pixel, frame_done, shift_error, overrun
  );
endinterface

// File: rtl/display_capture_accum.sv
// Per-pixel on-time accumulators plus the dump buffer read out one column at a time.
module display_capture_accum #(
  parameter int unsigned np      = 3,
  parameter int unsigned columns = 32,
  parameter int unsigned iw      = 5,
  parameter int unsigned cw      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [columns*np-1:0] lit,
  input  logic                  inc,
  input  logic                  clear,
  input  logic                  copy,
  input  logic [cw-1:0]         rd_col,
  output logic [iw*np-1:0]      rd_pixel
);
  logic [iw-1:0] acc     [columns][np];
  logic [iw-1:0] acc_inc [columns][np];
  logic [iw-1:0] dbuf    [columns][np];

  // Increment is computed first so a coincident copy sees the post-increment value.
  always_comb begin
    acc_inc = acc;
    for (int unsigned c = 0; c < columns; c++) begin
      for (int unsigned p = 0; p < np; p++) begin
        if (inc && lit[c*np+p] && (acc[c][p] != '1)) begin
          acc_inc[c][p] = acc[c][p] + iw'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '{default: '0};
      dbuf <= '{default: '0};
    end else begin
      for (int unsigned c = 0; c < columns; c++) begin
        for (int unsigned p = 0; p < np; p++) begin
          acc[c][p] <= clear ? '0 : acc_inc[c][p];
        end
      end
      if (copy) begin
        dbuf <= acc_inc;
      end
    end
  end

  always_comb begin
    rd_pixel = '0;
    for (int unsigned p = 0; p < np; p++) begin
      rd_pixel[p*iw +: iw] = dbuf[rd_col][p];
    end
  end
endmodule

// File: rtl/display_capture.sv
// Captures a serial LED-panel stream, integrates PWM on-time per pixel and dumps each row.
module display_capture import display_capture_pkg::*; #(
  parameter int unsigned segments   = DEF_SEGMENTS,
  parameter int unsigned rows       = DEF_ROWS,
  parameter int unsigned columns    = DEF_COLUMNS,
  parameter int unsigned cyclewidth = DEF_CYCLEWIDTH
) (
  input logic             clk,
  input logic             rst,
  display_capture_if.slave bus
);
  localparam int unsigned NP  = 3 * segments;
  localparam int unsigned IW  = cyclewidth + 1;
  localparam int unsigned RW  = (rows > 1) ? $clog2(rows) : 1;
  localparam int unsigned CW  = (columns > 1) ? $clog2(columns) : 1;
  localparam int unsigned SCW = $clog2(columns + 2);

  logic oclk_q, lat_q, oe_q;
  logic oclk_rise, lat_rise, oe_fall;
  logic [NP-1:0]  sr      [columns];
  logic [NP-1:0]  sr_next [columns];
  logic [NP-1:0]  lat_reg [columns];
  logic [SCW-1:0] shift_cnt, shift_cnt_next;
  logic [RW-1:0]  acc_row, dump_row;
  logic           acc_row_vld;
  logic           commit, accept;
  logic           shift_error_q, overrun_q, frame_done_q, frame_done_next;
  logic           dump_valid;
  logic [CW-1:0]  col, col_next;
  logic [columns*NP-1:0] lit;
  logic [IW*NP-1:0]      rd_pixel;
  dump_state_t    state, state_next;

  assign oclk_rise = bus.oclk & ~oclk_q;
  assign lat_rise  = bus.lat & ~lat_q;
  assign oe_fall   = oe_q & ~bus.oe;
  assign commit    = lat_rise & acc_row_vld & (bus.row != acc_row);
  assign accept    = commit & (state == ST_IDLE);

  // First-shifted sample drifts down to index 0 after a full row of shifts.
  always_comb begin
    sr_next        = sr;
    shift_cnt_next = shift_cnt;
    if (oclk_rise) begin
      for (int unsigned c = 0; c + 1 < columns; c++) begin
        sr_next[c] = sr[c+1];
      end
      sr_next[columns-1] = bus.rgb;
      if (shift_cnt != SCW'(columns + 1)) begin
        shift_cnt_next = shift_cnt + SCW'(1);
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int unsigned c = 0; c < columns; c++) begin
      for (int unsigned p = 0; p < NP; p++) begin
        lit[c*NP+p] = lat_reg[c][p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oclk_q        <= 1'b0;
      lat_q         <= 1'b0;
      oe_q          <= 1'b0;
      sr            <= '{default: '0};
      lat_reg       <= '{default: '0};
      shift_cnt     <= '0;
      acc_row       <= '0;
      acc_row_vld   <= 1'b0;
      shift_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      oclk_q <= bus.oclk;
      lat_q  <= bus.lat;
      oe_q   <= bus.oe;
      sr     <= sr_next;
      if (lat_rise) begin
        lat_reg     <= sr_next;
        shift_cnt   <= '0;
        acc_row     <= bus.row;
        acc_row_vld <= 1'b1;
        if (shift_cnt_next != SCW'(columns)) shift_error_q <= 1'b1;
        if (commit && (state == ST_DUMP))    overrun_q     <= 1'b1;
      end else begin
        shift_cnt <= shift_cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      col          <= '0;
      dump_row     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      col          <= col_next;
      frame_done_q <= frame_done_next;
      if (accept) dump_row <= acc_row;
    end
  end

  always_comb begin
    state_next      = state;
    col_next        = col;
    dump_valid      = 1'b0;
    frame_done_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_DUMP;
          col_next   = '0;
        end
      end
      ST_DUMP: begin
        dump_valid = 1'b1;
        col_next   = col + CW'(1);
        if (col == CW'(columns - 1)) begin
          state_next      = ST_IDLE;
          col_next        = '0;
          frame_done_next = (dump_row == RW'(rows - 1));
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  display_capture_accum #(
    .np      (NP),
    .columns (columns),
    .iw      (IW),
    .cw      (CW)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .lit      (lit),
    .inc      (oe_fall),
    .clear    (commit),
    .copy     (accept),
    .rd_col   (col),
    .rd_pixel (rd_pixel)
  );

  assign bus.wr_valid    = dump_valid;
  assign bus.wr_row      = dump_valid ? dump_row : '0;
  assign bus.wr_column   = dump_valid ? col : '0;
  assign bus.wr_pixel    = dump_valid ? rd_pixel : '0;
  assign bus.frame_done  = frame_done_q;
  assign bus.shift_error = shift_error_q;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_display_capture.sv
// Checks display_capture against a queue/array based behavioural model, directed and random.
module tb_display_capture;
  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int MAXV = 7;

  typedef struct {
    int         row;
    int         col;
    logic [8:0] pix;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  display_capture_if #(.segments(1), .rows(2), .columns(4), .cyclewidth(2)) bus ();

  display_capture #(.segments(1), .rows(2), .columns(4), .cyclewidth(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  wr_t wlog[$];
  int frame_cnt = 0;

  // model state
  logic [2:0] m_sh[$];
  logic [2:0] m_lat[COLS];
  int         m_acc[COLS][3];
  int         m_cnt, m_acc_row;
  bit         m_loaded, m_serr, m_ovr, m_frame, m_valid;
  bit         p_oclk, p_lat, p_oe;
  wr_t        m_pend[$];
  wr_t        m_cur;

  logic [2:0] i_rgb = '0;
  logic i_oclk = 0, i_lat = 0, i_oe = 0, i_row = 0, i_rst = 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_sh.delete();
    for (int c = 0; c < COLS; c++) begin
      m_sh.push_back(3'b000);
      m_lat[c] = 3'b000;
      for (int k = 0; k < 3; k++) m_acc[c][k] = 0;
    end
    m_cnt = 0; m_acc_row = 0; m_loaded = 0; m_serr = 0; m_ovr = 0;
    m_frame = 0; m_valid = 0; p_oclk = 0; p_lat = 0; p_oe = 0;
    m_pend.delete();
    m_cur = '{row: 0, col: 0, pix: '0};
  endfunction

  function automatic void model_step(input logic r, input logic [2:0] d, input logic oc,
                                     input logic la, input logic o, input logic rw);
    bit orise, lrise, ofall, busy, last_done;
    if (r) begin
      model_reset();
      return;
    end
    orise = oc && !p_oclk;
    lrise = la && !p_lat;
    ofall = !o && p_oe;
    p_oclk = oc; p_lat = la; p_oe = o;
    busy = m_valid;
    last_done = m_valid && (m_cur.col == COLS-1) && (m_cur.row == ROWS-1);
    if (orise) begin
      m_sh.push_back(d);
      void'(m_sh.pop_front());
      m_cnt = (m_cnt + 1 > COLS + 1) ? COLS + 1 : m_cnt + 1;
    end
    if (ofall)
      for (int c = 0; c < COLS; c++)
        for (int k = 0; k < 3; k++)
          if (m_lat[c][k] && m_acc[c][k] < MAXV) m_acc[c][k]++;
    if (lrise) begin
      for (int c = 0; c < COLS; c++) m_lat[c] = m_sh[c];
      if (m_cnt != COLS) m_serr = 1;
      m_cnt = 0;
      if (m_loaded && int'(rw) != m_acc_row) begin
        if (busy) m_ovr = 1;
        else
          for (int c = 0; c < COLS; c++)
            m_pend.push_back('{row: m_acc_row, col: c,
                               pix: {3'(m_acc[c][2]), 3'(m_acc[c][1]), 3'(m_acc[c][0])}});
        for (int c = 0; c < COLS; c++)
          for (int k = 0; k < 3; k++) m_acc[c][k] = 0;
      end
      m_acc_row = int'(rw);
      m_loaded = 1;
    end
    m_frame = last_done;
    if (m_pend.size() > 0) begin
      m_cur = m_pend.pop_front();
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_valid", 32'(bus.wr_valid), 32'(m_valid));
      if (m_valid) begin
        check("wr_row", 32'(bus.wr_row), 32'(m_cur.row));
        check("wr_column", 32'(bus.wr_column), 32'(m_cur.col));
        check("wr_pixel", 32'(bus.wr_pixel), 32'(m_cur.pix));
      end
      check("frame_done", 32'(bus.frame_done), 32'(m_frame));
      check("shift_error", 32'(bus.shift_error), 32'(m_serr));
      check("overrun", 32'(bus.overrun), 32'(m_ovr));
    end
    if (bus.wr_valid === 1'b1)
      wlog.push_back('{row: int'(bus.wr_row), col: int'(bus.wr_column), pix: bus.wr_pixel});
    if (bus.frame_done === 1'b1) frame_cnt++;
  end

  task automatic step();
    rst = i_rst; bus.rgb = i_rgb; bus.oclk = i_oclk; bus.lat = i_lat;
    bus.oe = i_oe; bus.row = i_row;
    @(posedge clk);
    model_step(i_rst, i_rgb, i_oclk, i_lat, i_oe, i_row);
    #1;
  endtask

  task automatic shift(input logic [2:0] d);
    i_rgb = d; i_oclk = 1; step(); i_oclk = 0; step();
  endtask
  task automatic shift4(input logic [2:0] d);
    repeat (4) shift(d);
  endtask
  task automatic latch(input logic r);
    i_row = r; i_lat = 1; step(); i_lat = 0; step();
  endtask
  task automatic oe_pulses(input int n);
    repeat (n) begin i_oe = 1; step(); i_oe = 0; step(); end
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic check_dump(input string name, input int row, input logic [8:0] pix0,
                            input logic [8:0] pix_rest);
    check({name, "_count"}, 32'(wlog.size()), 32'(COLS));
    for (int i = 0; i < wlog.size() && i < COLS; i++) begin
      check({name, "_row"}, 32'(wlog[i].row), 32'(row));
      check({name, "_col"}, 32'(wlog[i].col), 32'(i));
      check({name, "_pix"}, 32'(wlog[i].pix), 32'((i == 0) ? pix0 : pix_rest));
    end
  endtask

  initial begin
    int fc0;
    model_reset();
    i_rst = 1; step(); step();
    chk_en = 1;
    i_rst = 0;
    @(negedge clk);
    check("rst_valid", 32'(bus.wr_valid), 0);
    check("rst_pixel", 32'(bus.wr_pixel), 0);
    check("rst_serr", 32'(bus.shift_error), 0);
    check("rst_ovr", 32'(bus.overrun), 0);

    // V1: red lit on every column for 3 PWM cycles
    i_row = 0;
    shift4(3'b001); latch(0); oe_pulses(3);
    shift4(3'b001); wlog.delete(); latch(1); idle(8);
    check_dump("v1", 0, 9'd3, 9'd3);

    // V2: only column 0 lit in all colours
    shift(3'b111); shift(3'b000); shift(3'b000); shift(3'b000);
    latch(1); oe_pulses(1);
    fc0 = frame_cnt;
    shift4(3'b000); wlog.delete(); latch(0); idle(8);
    check_dump("v2", 1, 9'h049, 9'h000);
    check("v2_frame", 32'(frame_cnt), 32'(fc0 + 1));

    // V3: below saturation, then saturating
    shift4(3'b001); latch(0); oe_pulses(5);
    shift4(3'b001); wlog.delete(); latch(1); idle(8);
    check_dump("v3a", 0, 9'd5, 9'd5);
    oe_pulses(9);
    shift4(3'b001); wlog.delete(); latch(0); idle(8);
    check_dump("v3b", 1, 9'd7, 9'd7);
    check("v3_serr_clear", 32'(bus.shift_error), 0);

    // V4: short shift sequence
    shift(3'b010); shift(3'b010); shift(3'b010); latch(0); idle(2);
    check("v4_serr", 32'(bus.shift_error), 1);

    // V5: second commit arrives while the first is still dumping
    shift4(3'b100); latch(1); idle(8);
    fc0 = frame_cnt;
    shift4(3'b100); wlog.delete(); latch(0); latch(1); idle(10);
    check("v5_ovr", 32'(bus.overrun), 1);
    check("v5_count", 32'(wlog.size()), 32'(COLS));
    check("v5_frame", 32'(frame_cnt), 32'(fc0 + 1));
    check("v4_serr_sticky", 32'(bus.shift_error), 1);

    // V6: reset during the second write of a dump
    shift4(3'b001); wlog.delete(); latch(0);
    i_rst = 1; step(); i_rst = 0;
    @(negedge clk);
    check("v6_writes", 32'(wlog.size()), 2);
    check("v6_valid", 32'(bus.wr_valid), 0);
    check("v6_pixel", 32'(bus.wr_pixel), 0);
    check("v6_serr", 32'(bus.shift_error), 0);
    check("v6_ovr", 32'(bus.overrun), 0);
    check("v6_frame", 32'(bus.frame_done), 0);

    // random phase, checked cycle by cycle against the model
    repeat (1500) begin
      i_rgb  = 3'($urandom_range(0, 7));
      i_oclk = 1'($urandom_range(0, 1));
      i_lat  = ($urandom_range(0, 7) == 0);
      i_oe   = 1'($urandom_range(0, 1));
      i_row  = 1'($urandom_range(0, 1));
      i_rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    i_rst = 0; i_lat = 0; i_oclk = 0; i_oe = 0;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- segments, 1, parallel RGB lanes.
- rows, 8, addressable rows.
- columns, 32, shifts per latch.
- cyclewidth, 4, PWM cycle bits; intensity width IW = cyclewidth+1.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- rgb, in, 3*segments, serial pixel bits; bit 3*s+c = segment s, colour c.
- oclk, in, 1, shift clock, sampled.
- lat, in, 1, latch strobe, sampled.
- oe, in, 1, output enable, high = displaying.
- row, in, clog2(rows), row address.
- wr_valid, out, 1, pixel write strobe.
- wr_row, out, clog2(rows), row of write.
- wr_column, out, clog2(columns), column of write.
- wr_pixel, out, IW*3*segments, intensities; field [IW*(3*s+c) +: IW].
- frame_done, out, 1, one-cycle pulse after a commit of row rows-1.
- shift_error, out, 1, sticky.
- overrun, out, 1, sticky.

Function
REQ-003 All panel inputs SHALL be sampled on clk; edges are detected against the previous sample; no synchronizers.
REQ-004 On an oclk rising edge, rgb SHALL be shifted into a columns-deep shift register and the shift count incremented, saturating at columns+1.
REQ-005 After columns shifts, the first-shifted sample SHALL map to column 0.
REQ-006 On a lat rising edge, the shift register SHALL copy into the latch register.
- The shift count SHALL clear.
- If the count != columns, shift_error SHALL set.
REQ-007 oclk and lat rising in the same cycle: the shift SHALL apply first, then the latch captures the shifted contents.
REQ-008 On an oe falling edge, each per-pixel accumulator (IW bits) whose latch bit is 1 SHALL increment by 1, saturating at 2^IW-1.
REQ-009 acc_row SHALL load row at the first lat edge after reset.
REQ-010 A lat rising edge with row != acc_row SHALL commit:
- The accumulators copy to the dump buffer.
- The accumulators clear.
- acc_row <= row.
- This happens in the same cycle as the REQ-006 latch.
REQ-011 Dump FSM states IDLE and DUMP.
- IDLE -> DUMP on commit.
- In DUMP, wr_valid=1 for exactly columns consecutive cycles, starting the cycle after the commit.
- wr_column runs 0..columns-1; wr_row = committed row.
- DUMP -> IDLE after column columns-1.
REQ-012 wr_valid has no backpressure; the sink SHALL accept every write.
REQ-013 A commit arriving while in DUMP SHALL be dropped: the accumulators still clear, the buffer is unchanged, and overrun sets.
REQ-014 frame_done SHALL pulse in the cycle after the last write of a dump whose wr_row = rows-1.
REQ-015 An oe falling edge coinciding with a commit SHALL increment the accumulators first, then commit.

Reset
REQ-016 On rst the following SHALL be 0: all outputs, the shift register, latch register, accumulators, dump buffer, counters, edge history and acc_row; FSM = IDLE.
REQ-017 rst mid-dump SHALL abort the dump with no further wr_valid.
REQ-018 Sticky flags SHALL clear only on rst.

Structure
REQ-019 The shared package SHALL hold the dump FSM state enum and the default parameter constants.
REQ-020 One sub-module, display_capture_accum, SHALL hold the accumulator bank and dump buffer, including increment, clear and copy.
REQ-021 The RTL SHALL be sized for 120-400 lines.

Verification
REQ-022 Bench parameters: columns=4, rows=2, segments=1, cyclewidth=2. The bench SHALL cover:
- V1: row 0; 4 shifts of rgb=3'b001; lat; 3 oe pulses; then lat with row=1 -> 4 writes, wr_row=0, red=3, green=0, blue=0, columns 0..3.
- V2: shifts 3'b111,000,000,000; lat; 1 oe pulse; commit -> column 0 = (1,1,1), columns 1..3 = 0.
- V3: 5 oe pulses with a lit bit (IW=3, max 7) -> no saturation; 9 pulses -> value 7.
- V4: 3 shifts then lat -> shift_error=1 and stays 1 until rst.
- V5: second row change within 2 cycles of a commit -> overrun=1, exactly 4 writes; the commit of row 1 sets frame_done once.
- V6: rst asserted at the 2nd dump write -> wr_valid=0 next cycle, all outputs 0.
